upsample_writer: RTL

- Write-back end of the upsampling datapath: takes the stream of 8-bit upsampled pixels and packs pairs into 16-bit memory words.
- Issues single-cycle writes to the 18-bit-addressed image memory, starting at a base address latched on start.
- Tracks column and row position, pads odd-width rows, and signals completion so the controller can sequence the next frame.

---
 rtl/upsample_pkg.sv | 14 +
 rtl/upsample_writer_if.sv | 22 ++
 rtl/upwr_pos_cnt.sv | 39 +++
 rtl/upsample_writer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/upsample_pkg.sv
// Shared constants and state type for the upsample writer and reader datapaths.
package upsample_pkg;

   localparam int unsigned ADDR_W = 18;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned PIX_W  = 8;
   // Wide enough for positions 0..4095
   localparam int unsigned CNT_W  = 12;

   localparam logic [PIX_W-1:0] PAD_BYTE = 8'h00;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} upwr_state_t;

endpackage

// File: rtl/upsample_writer_if.sv
// Pixel stream in / memory write bus out of the upsample writer.
interface upsample_writer_if;
   import upsample_pkg::*;

   logic [PIX_W-1:0]  pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              w_enb;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;

   modport master (
      input  pix_data, pix_valid,
      output pix_ready, w_enb, w_addr, w_data
   );

   modport slave (
      output pix_data, pix_valid,
      input  pix_ready, w_enb, w_addr, w_data
   );

endinterface

// File: rtl/upwr_pos_cnt.sv
// Column/row position counter for a raster frame; flags the last pixel of a row and of the frame.
module upwr_pos_cnt
   import upsample_pkg::*;
#(
   parameter int unsigned IMG_W = 512,
   parameter int unsigned IMG_H = 512
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic advance_i,
   output logic row_end_o,
   output logic frame_end_o
);

   logic [CNT_W-1:0] col_q;
   logic [CNT_W-1:0] row_q;

   assign row_end_o   = (col_q == CNT_W'(IMG_W - 1));
   assign frame_end_o = row_end_o && (row_q == CNT_W'(IMG_H - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q <= '0;
         row_q <= '0;
      end else if (clear_i) begin
         col_q <= '0;
         row_q <= '0;
      end else if (advance_i) begin
         if (row_end_o) begin
            col_q <= '0;
            row_q <= frame_end_o ? '0 : row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/upsample_writer.sv
// Packs upsampled 8-bit pixels into 16-bit memory words, padding odd-width rows.
// Optional running word checksum enabled by UPWR_CHECKSUM_EN.
module upsample_writer
   import upsample_pkg::*;
#(
   parameter int unsigned IMG_W = 512,
   parameter int unsigned IMG_H = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   upsample_writer_if.master    bus,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          checksum
);

   upwr_state_t       state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] w_addr_q;
   logic [DATA_W-1:0] w_data_q;
   logic [PIX_W-1:0]  hi_q;
   logic              byte_sel_q;
   logic              last_row_q;
   logic              w_enb_q;
   logic              pix_ready_q;
   logic              busy_q;
   logic              done_q;

   logic accept;
   logic start_acc;
   logic row_end;
   logic frame_end;

   assign accept    = bus.pix_valid && pix_ready_q;
   assign start_acc = start && (state_q == IDLE);

   upwr_pos_cnt #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_pos_cnt (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (start_acc),
      .advance_i   (accept),
      .row_end_o   (row_end),
      .frame_end_o (frame_end)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         w_addr_q    <= '0;
         w_data_q    <= '0;
         hi_q        <= '0;
         byte_sel_q  <= 1'b0;
         last_row_q  <= 1'b0;
         w_enb_q     <= 1'b0;
         pix_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         w_enb_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q      <= base_addr;
                  byte_sel_q  <= 1'b0;
                  last_row_q  <= 1'b0;
                  pix_ready_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  if (!byte_sel_q) begin
                     hi_q       <= bus.pix_data;
                     byte_sel_q <= 1'b1;
                     // Row ended on a half word: pad it out before continuing
                     if (row_end) begin
                        last_row_q  <= frame_end;
                        pix_ready_q <= 1'b0;
                        state_q     <= FLUSH;
                     end
                  end else begin
                     w_enb_q    <= 1'b1;
                     w_addr_q   <= addr_q;
                     w_data_q   <= {hi_q, bus.pix_data};
                     addr_q     <= addr_q + 1'b1;
                     byte_sel_q <= 1'b0;
                     if (frame_end) begin
                        pix_ready_q <= 1'b0;
                        state_q     <= DONE;
                     end
                  end
               end
            end
            FLUSH: begin
               w_enb_q    <= 1'b1;
               w_addr_q   <= addr_q;
               w_data_q   <= {hi_q, PAD_BYTE};
               addr_q     <= addr_q + 1'b1;
               byte_sel_q <= 1'b0;
               if (last_row_q) begin
                  state_q <= DONE;
               end else begin
                  pix_ready_q <= 1'b1;
                  state_q     <= RUN;
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.pix_ready = pix_ready_q;
   assign bus.w_enb     = w_enb_q;
   assign bus.w_addr    = w_addr_q;
   assign bus.w_data    = w_data_q;
   assign busy          = busy_q;
   assign done          = done_q;

`ifdef UPWR_CHECKSUM_EN
   logic [15:0] csum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csum_q <= '0;
      end else if (start_acc) begin
         csum_q <= '0;
      end else if (w_enb_q) begin
         csum_q <= csum_q + w_data_q;
      end
   end

   assign checksum = csum_q;
`else
   assign checksum = 16'h0000;
`endif

endmodule
